mask_generation_param: RTL

MASK_GENERATION_PARAM -- requirements
Module: mask_generation_param

---
 rtl/mask_gen_pkg.sv | 29 ++
 rtl/mask_lfsr.sv | 23 ++
 rtl/mask_generation_param.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mask_gen_pkg.sv
// Shared types, constants and the LFSR step function for the row-mask generator.
package mask_gen_pkg;

   typedef enum logic [1:0] {
      SLIDE_R = 2'b00,
      SLIDE_L = 2'b01,
      RANDOM  = 2'b10,
      REPEAT  = 2'b11
   } mask_type_e;

   typedef enum logic {
      IDLE = 1'b0,
      GEN  = 1'b1
   } state_e;

   localparam int unsigned LFSR_W      = 32;
   localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;

   localparam int unsigned DEF_H_RES   = 640;
   localparam int unsigned DEF_V_RES   = 480;
   localparam int unsigned DEF_PAT_MAX = 32;
   localparam int unsigned DEF_RP_W    = 8;

   // One Galois step: shift toward bit 0, fold the polynomial in when a one drops out.
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/mask_lfsr.sv
// 32-bit Galois LFSR: loadable seed, advances one step when step is high.
module mask_lfsr
   import mask_gen_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [LFSR_W-1:0]   seed,
   input  logic                load,
   input  logic                step,
   output logic [LFSR_W-1:0]   state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= '0;
      end else if (load) begin
         state <= seed;
      end else if (step) begin
         state <= lfsr_next(state);
      end
   end

endmodule

// File: rtl/mask_generation_param.sv
// Frame row-mask generator: sliding, LFSR-random or tiled rows with valid/ready handshake.
module mask_generation_param
   import mask_gen_pkg::*;
#(
   parameter int unsigned H_RES   = DEF_H_RES,
   parameter int unsigned V_RES   = DEF_V_RES,
   parameter int unsigned PAT_MAX = DEF_PAT_MAX,
   parameter int unsigned RP_W    = DEF_RP_W
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    clk_en,
   input  logic [1:0]                              mask_type,
   input  logic [((PAT_MAX > 1) ? $clog2(PAT_MAX) : 1)-1:0] pattern_w,
   input  logic                                    pattern,
   input  logic                                    load_pattern,
   input  logic [RP_W-1:0]                         rep_pattern,
   input  logic                                    start,
   input  logic                                    mask_ready,
   output logic [0:H_RES-1]                        mask_out,
   output logic                                    mask_valid,
   output logic                                    row_last,
   output logic                                    busy
);

   localparam int unsigned PW_W  = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
   localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

   state_e                 state, state_d;
   mask_type_e             mode_q;
   logic [0:PAT_MAX-1]     pat_reg;
   logic [0:PAT_MAX-1]     pat_shift;
   logic [PW_W-1:0]        shamt;
   logic [ROW_W-1:0]       row_cnt;
   logic [LFSR_W-1:0]      seed_raw, seed, lfsr_state, lfsr_adv;
   logic [0:H_RES-1]       slide_first, rot_r, rot_l, rep_tile, seed_tile, adv_tile;
   logic [0:H_RES-1]       mask_d;
   logic                   start_go, xfer, done, pat_load;

   // Seed is the last 32 loaded bits (most recent = bit 0); a zero seed would lock up.
   for (genvar k = 0; k < LFSR_W; k++) begin : g_seed
      if (k < PAT_MAX) begin : g_in
         assign seed_raw[k] = pat_reg[PAT_MAX-1-k];
      end else begin : g_pad
         assign seed_raw[k] = 1'b0;
      end
   end
   assign seed = (seed_raw == '0) ? 32'h1 : seed_raw;

   // Bring the newest L pattern bits up to index 0, zeros behind them.
   assign shamt     = PW_W'(PAT_MAX - 1) - pattern_w;
   assign pat_shift = pat_reg << shamt;
   assign lfsr_adv  = lfsr_next(lfsr_state);

   for (genvar i = 0; i < H_RES; i++) begin : g_bit
      assign rep_tile[i]  = rep_pattern[RP_W-1-(i % RP_W)];
      assign seed_tile[i] = seed[i % LFSR_W];
      assign adv_tile[i]  = lfsr_adv[i % LFSR_W];
      assign rot_r[i]     = mask_out[(i + H_RES - 1) % H_RES];
      assign rot_l[i]     = mask_out[(i + 1) % H_RES];
      if (i < PAT_MAX) begin : g_pat
         assign slide_first[i] = pat_shift[i];
      end else begin : g_zero
         assign slide_first[i] = 1'b0;
      end
   end

   mask_lfsr u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .seed  (seed),
      .load  (start_go),
      .step  (xfer && (mode_q == RANDOM)),
      .state (lfsr_state)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // Next state and control strobes
   always_comb begin
      state_d  = state;
      start_go = 1'b0;
      xfer     = 1'b0;
      done     = 1'b0;
      pat_load = 1'b0;
      if (clk_en) begin
         case (state)
            IDLE: begin
               if (load_pattern) begin
                  pat_load = 1'b1;
               end else if (start) begin
                  start_go = 1'b1;
                  state_d  = GEN;
               end
            end
            GEN: begin
               if (mask_valid && mask_ready) begin
                  xfer = 1'b1;
                  if (row_last) begin
                     done    = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Next row selection
   always_comb begin
      mask_d = mask_out;
      if (start_go) begin
         case (mask_type_e'(mask_type))
            RANDOM:  mask_d = seed_tile;
            REPEAT:  mask_d = rep_tile;
            default: mask_d = slide_first;
         endcase
      end else if (xfer) begin
         case (mode_q)
            SLIDE_R: mask_d = rot_r;
            SLIDE_L: mask_d = rot_l;
            RANDOM:  mask_d = adv_tile;
            default: mask_d = mask_out;
         endcase
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_reg    <= '0;
         mode_q     <= SLIDE_R;
         row_cnt    <= '0;
         mask_out   <= '0;
         mask_valid <= 1'b0;
         busy       <= 1'b0;
         row_last   <= 1'b0;
      end else begin
         mask_out <= mask_d;
         if (pat_load) begin
            pat_reg <= {pat_reg[1:PAT_MAX-1], pattern};
         end
         if (start_go) begin
            mode_q     <= mask_type_e'(mask_type);
            row_cnt    <= '0;
            mask_valid <= 1'b1;
            busy       <= 1'b1;
            row_last   <= (V_RES == 1);
         end else if (done) begin
            row_cnt    <= '0;
            mask_valid <= 1'b0;
            busy       <= 1'b0;
            row_last   <= 1'b0;
         end else if (xfer) begin
            row_cnt  <= row_cnt + ROW_W'(1);
            row_last <= ((row_cnt + ROW_W'(1)) == ROW_W'(V_RES - 1));
         end
      end
   end

endmodule
